// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, registered training and lookup bypass.
// Optional BTB_STATS_EN adds saturating lookup/hit/mispredict counters.
module btb_predictor #(
    parameter  int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int TAG_W = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic [1:0]  btb_flag,
    output logic [31:0] btb_pc,
    input  logic        mem_stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic [1:0]  ex_pred_flag,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_mispred
`endif
);

    logic             r_valid  [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic [1:0]       r_ctr    [DEPTH];

    logic        r_upd_pend;
    logic [29:0] r_upd_pc;
    logic        r_upd_taken;
    logic [31:0] r_upd_target;
    logic        r_upd_br;

    logic             w_ev;
    logic             w_pred_tk;
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_we;
    logic             w_n_valid;
    logic [TAG_W-1:0] w_n_tag;
    logic [31:0]      w_n_target;
    logic [1:0]       w_n_ctr;
    logic             w_byp;
    logic             w_e_valid;
    logic [TAG_W-1:0] w_e_tag;
    logic [31:0]      w_e_target;
    logic [1:0]       w_e_ctr;
    logic             w_hit;
    logic             w_unused_bits;

    assign w_unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[31:IDX_W+2];
    assign w_u_idx  = r_upd_pc[IDX_W-1:0];
    assign w_u_tag  = r_upd_pc[29:IDX_W];
    assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    // Next value of the entry addressed by the pending update
    always_comb begin
        w_we       = 1'b0;
        w_n_valid  = r_valid[w_u_idx];
        w_n_tag    = r_tag[w_u_idx];
        w_n_target = r_target[w_u_idx];
        w_n_ctr    = r_ctr[w_u_idx];
        if (r_upd_pend) begin
            if (r_upd_br) begin
                if (w_u_hit) begin
                    w_we = 1'b1;
                    if (r_upd_taken) begin
                        w_n_target = r_upd_target;
                        if (w_n_ctr != 2'b11)
                            w_n_ctr = w_n_ctr + 2'd1;
                    end else if (w_n_ctr != 2'b00) begin
                        w_n_ctr = w_n_ctr - 2'd1;
                    end
                end else if (r_upd_taken) begin
                    w_we       = 1'b1;
                    w_n_valid  = 1'b1;
                    w_n_tag    = w_u_tag;
                    w_n_target = r_upd_target;
                    w_n_ctr    = 2'b10;
                end
            end else if (w_u_hit) begin
                w_we      = 1'b1;
                w_n_valid = 1'b0;
            end
        end
    end

    // Write-before-read: lookup sees the entry as it will be after commit
    assign w_byp = w_we && (w_u_idx == w_if_idx);

    always_comb begin
        w_e_valid  = r_valid[w_if_idx];
        w_e_tag    = r_tag[w_if_idx];
        w_e_target = r_target[w_if_idx];
        w_e_ctr    = r_ctr[w_if_idx];
        if (w_byp) begin
            w_e_valid  = w_n_valid;
            w_e_tag    = w_n_tag;
            w_e_target = w_n_target;
            w_e_ctr    = w_n_ctr;
        end
    end

    assign w_hit    = w_e_valid && (w_e_tag == w_if_tag);
    assign btb_flag = {w_hit, w_hit & w_e_ctr[1]};
    assign btb_pc   = w_hit ? w_e_target : 32'h0;

    assign w_ev      = ex_valid & ~mem_stall & ~rst;
    assign w_pred_tk = (ex_pred_flag == 2'b11);

    assign mispredict = w_ev & (
        (ex_is_branch & (ex_taken != w_pred_tk)) |
        (ex_is_branch & ex_taken & w_pred_tk &
         (ex_target != ex_pred_target)) |
        (~ex_is_branch & w_pred_tk));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd_pend   <= 1'b0;
            r_upd_pc     <= '0;
            r_upd_taken  <= 1'b0;
            r_upd_target <= '0;
            r_upd_br     <= 1'b0;
        end else begin
            r_upd_pend <= w_ev;
            if (w_ev) begin
                r_upd_pc     <= ex_pc[31:2];
                r_upd_taken  <= ex_taken;
                r_upd_target <= ex_target;
                r_upd_br     <= ex_is_branch;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_we) begin
            r_valid[w_u_idx]  <= w_n_valid;
            r_tag[w_u_idx]    <= w_n_tag;
            r_target[w_u_idx] <= w_n_target;
            r_ctr[w_u_idx]    <= w_n_ctr;
        end
    end

`ifdef BTB_STATS_EN
    logic r_dummy_unused;
    assign r_dummy_unused = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_mispred <= '0;
        end else begin
            if (w_ev && ex_is_branch && stat_lookups != 32'hFFFF_FFFF)
                stat_lookups <= stat_lookups + 32'd1;
            if (w_ev && ex_is_branch && ex_pred_flag[1] &&
                stat_hits != 32'hFFFF_FFFF)
                stat_hits <= stat_hits + 32'd1;
            if (mispredict && stat_mispred != 32'hFFFF_FFFF)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed vector bench for btb_predictor: per-cycle table plus reset-mid-pending sequence.
module tb_btb_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic [1:0]  btb_flag;
    logic [31:0] btb_pc;
    logic        mem_stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [1:0]  ex_pred_flag;
    logic [31:0] ex_pred_target;
    logic        mispredict;

    int n_cmp;
    int n_bad;

    btb_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .btb_flag       (btb_flag),
        .btb_pc         (btb_pc),
        .mem_stall      (mem_stall),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_flag   (ex_pred_flag),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ipc;
        logic        stall;
        logic        ev;
        logic        br;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic [1:0]  pf;
        logic [31:0] pt;
        logic [1:0]  e_flag;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] ipc, input logic stall,
                       input logic ev, input logic br,
                       input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic [1:0] pf,
                       input logic [31:0] pt, input logic [1:0] ef,
                       input logic [31:0] ep, input logic em);
        vec_t v;
        v.ipc = ipc; v.stall = stall; v.ev = ev; v.br = br;
        v.pc = pc; v.tk = tk; v.tgt = tgt; v.pf = pf; v.pt = pt;
        v.e_flag = ef; v.e_pc = ep; v.e_mis = em;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_ex();
        mem_stall = 0; ex_valid = 0; ex_is_branch = 0; ex_pc = 0;
        ex_taken = 0; ex_target = 0; ex_pred_flag = 0;
        ex_pred_target = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        if_pc = 32'h100;
        idle_ex();

        //  ipc     st ev br pc      tk tgt     pf     pt      flag   pc      mis
        add(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h100, 0, 1, 1, 32'h100, 1, 32'h200, 2'b00, 32'h0,   2'b00, 32'h0,   1);
        add(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b11, 32'h200, 0);
        add(32'h100, 0, 1, 1, 32'h100, 0, 32'h200, 2'b11, 32'h200, 2'b11, 32'h200, 1);
        add(32'h100, 0, 1, 1, 32'h100, 0, 32'h200, 2'b10, 32'h200, 2'b10, 32'h200, 0);
        add(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b10, 32'h200, 0);
        add(32'h100, 0, 1, 1, 32'h100, 1, 32'h300, 2'b11, 32'h200, 2'b10, 32'h200, 1);
        add(32'h100, 0, 1, 1, 32'h100, 1, 32'h300, 2'b10, 32'h300, 2'b10, 32'h300, 1);
        add(32'h100, 0, 1, 1, 32'h100, 1, 32'h300, 2'b10, 32'h300, 2'b11, 32'h300, 1);
        add(32'h100, 0, 1, 1, 32'h100, 1, 32'h300, 2'b11, 32'h300, 2'b11, 32'h300, 0);
        add(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b11, 32'h300, 0);
        add(32'h104, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h100, 0, 1, 0, 32'h100, 0, 32'h0,   2'b11, 32'h300, 2'b11, 32'h300, 1);
        add(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h200, 0, 1, 1, 32'h200, 1, 32'h400, 2'b00, 32'h0,   2'b00, 32'h0,   1);
        add(32'h200, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b11, 32'h400, 0);
        add(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h100, 1, 1, 1, 32'h100, 1, 32'h500, 2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h100, 1, 1, 1, 32'h100, 1, 32'h500, 2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h100, 1, 1, 1, 32'h100, 1, 32'h500, 2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h200, 0, 1, 0, 32'h200, 0, 32'h0,   2'b00, 32'h0,   2'b11, 32'h400, 0);
        add(32'h200, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h108, 0, 0, 1, 32'h108, 1, 32'h700, 2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h108, 0, 1, 1, 32'h108, 0, 32'h700, 2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h108, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b00, 32'h0,   0);
        add(32'h100, 0, 1, 1, 32'h100, 1, 32'h200, 2'b00, 32'h0,   2'b00, 32'h0,   1);
        add(32'h100, 0, 1, 1, 32'h100, 0, 32'h200, 2'b11, 32'h200, 2'b11, 32'h200, 1);
        add(32'h100, 1, 1, 1, 32'h100, 1, 32'h200, 2'b00, 32'h0,   2'b10, 32'h200, 0);
        add(32'h100, 1, 1, 1, 32'h100, 1, 32'h200, 2'b00, 32'h0,   2'b10, 32'h200, 0);
        add(32'h100, 0, 1, 1, 32'h100, 1, 32'h200, 2'b10, 32'h200, 2'b10, 32'h200, 1);
        add(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   2'b00, 32'h0,   2'b11, 32'h200, 0);

        @(posedge clk);
        @(negedge clk);
        chk("reset_flag", {30'd0, btb_flag}, 32'd0);
        chk("reset_pc", btb_pc, 32'd0);
        chk("reset_mis", {31'd0, mispredict}, 32'd0);
        rst = 1'b0;

        foreach (vq[k]) begin
            @(posedge clk);
            #1;
            if_pc          = vq[k].ipc;
            mem_stall      = vq[k].stall;
            ex_valid       = vq[k].ev;
            ex_is_branch   = vq[k].br;
            ex_pc          = vq[k].pc;
            ex_taken       = vq[k].tk;
            ex_target      = vq[k].tgt;
            ex_pred_flag   = vq[k].pf;
            ex_pred_target = vq[k].pt;
            @(negedge clk);
            chk($sformatf("v%0d_flag", k), {30'd0, btb_flag},
                {30'd0, vq[k].e_flag});
            chk($sformatf("v%0d_pc", k), btb_pc, vq[k].e_pc);
            chk($sformatf("v%0d_mis", k), {31'd0, mispredict},
                {31'd0, vq[k].e_mis});
        end

        // Reset arriving while an update is pending
        @(posedge clk);
        #1;
        if_pc = 32'h140;
        idle_ex();
        ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h140;
        ex_taken = 1; ex_target = 32'h600; ex_pred_flag = 2'b00;
        @(negedge clk);
        chk("rp_mis", {31'd0, mispredict}, 32'd1);
        @(posedge clk);
        #1;
        chk("rp_bypass_flag", {30'd0, btb_flag}, 32'd3);
        chk("rp_bypass_pc", btb_pc, 32'h600);
        rst = 1'b1;
        #1;
        chk("rp_rst_flag", {30'd0, btb_flag}, 32'd0);
        chk("rp_rst_pc", btb_pc, 32'd0);
        chk("rp_rst_mis", {31'd0, mispredict}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_ex();
        @(negedge clk);
        chk("rp_after_flag", {30'd0, btb_flag}, 32'd0);
        if_pc = 32'h100;
        #1;
        chk("rp_after_old", {30'd0, btb_flag}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
